// File: rtl/game2048_pkg.sv
// rtl/game2048_pkg.sv - shared 2048 board types, sizes and win threshold helper
package game2048_pkg;

    localparam int TILE_W = 12;
    localparam int N      = 4;

    typedef logic [TILE_W-1:0] tile_t;
    typedef tile_t board_t [N-1:0][N-1:0];

    // One bit wider than a tile so a threshold above the tile range is representable.
    typedef logic [TILE_W:0] thr_t;

    // Winning threshold 1<<max_win; saturates to all-ones when no tile can reach it,
    // so a zero-extended tile compare never succeeds.
    function automatic thr_t win_threshold(input int max_win);
        if (max_win >= TILE_W) begin
            return '1;
        end
        return thr_t'(1) << max_win;
    endfunction

endpackage

// File: rtl/board_max_tree.sv
// rtl/board_max_tree.sv - 16-input unsigned maximum as a 4-level comparator tree
module board_max_tree
    import game2048_pkg::*;
(
    input  logic [N*N-1:0][TILE_W-1:0] tiles_i,
    output logic [TILE_W-1:0]          max_o
);

    tile_t lvl1 [8];
    tile_t lvl2 [4];
    tile_t lvl3 [2];

    // Pairwise reduction 16 -> 8 -> 4 -> 2 -> 1, keeping the larger of each pair.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl1[i] = (tiles_i[2*i] >= tiles_i[2*i+1]) ? tiles_i[2*i] : tiles_i[2*i+1];
        end
        for (int i = 0; i < 4; i++) begin
            lvl2[i] = (lvl1[2*i] >= lvl1[2*i+1]) ? lvl1[2*i] : lvl1[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            lvl3[i] = (lvl2[2*i] >= lvl2[2*i+1]) ? lvl2[2*i] : lvl2[2*i+1];
        end
        max_o = (lvl3[0] >= lvl3[1]) ? lvl3[0] : lvl3[1];
    end

endmodule

// File: rtl/check_win.sv
// rtl/check_win.sv - registered 4x4 board evaluator: win, empty, merge, game over, max tile
module check_win
    import game2048_pkg::*;
#(
    parameter int MAX_WIN = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N-1:0][N-1:0][TILE_W-1:0] board_in,
    output logic                            result,
    output logic                            has_empty,
    output logic                            can_merge,
    output logic                            game_over,
    output logic [TILE_W-1:0]               max_tile,
    output logic [1:0]                      win_row,
    output logic [1:0]                      win_col
);

    localparam thr_t WIN_THR = win_threshold(MAX_WIN);

    logic                      win_d, win_q;
    logic [1:0]                row_d, row_q;
    logic [1:0]                col_d, col_q;
    logic                      empty_d, empty_q;
    logic                      merge_d, merge_q;
    logic                      over_d, over_q;
    logic [TILE_W-1:0]         max_d, max_q;
    logic [N*N-1:0][TILE_W-1:0] tiles_flat;

    // Row-major flattening: entry r*N+c is board_in[r][c].
    assign tiles_flat = board_in;

    board_max_tree u_max_tree (
        .tiles_i (tiles_flat),
        .max_o   (max_d)
    );

    // First winning tile in row-major order; later hits are ignored once one is found.
    always_comb begin
        win_d = 1'b0;
        row_d = 2'd0;
        col_d = 2'd0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!win_d && ({1'b0, board_in[r][c]} >= WIN_THR)) begin
                    win_d = 1'b1;
                    row_d = 2'(r);
                    col_d = 2'(c);
                end
            end
        end
    end

    // Empty scan plus the 24 neighbour compares; an equal pair only counts if nonzero.
    always_comb begin
        empty_d = 1'b0;
        merge_d = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (board_in[r][c] == '0) begin
                    empty_d = 1'b1;
                end
                if (c < N-1) begin
                    if ((board_in[r][c] != '0) && (board_in[r][c] == board_in[r][c+1])) begin
                        merge_d = 1'b1;
                    end
                end
                if (r < N-1) begin
                    if ((board_in[r][c] != '0) && (board_in[r][c] == board_in[r+1][c])) begin
                        merge_d = 1'b1;
                    end
                end
            end
        end
        over_d = !empty_d && !merge_d && !win_d;
    end

    // Single output register stage; reset clears everything including has_empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q   <= 1'b0;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            empty_q <= 1'b0;
            merge_q <= 1'b0;
            over_q  <= 1'b0;
            max_q   <= '0;
        end else begin
            win_q   <= win_d;
            row_q   <= row_d;
            col_q   <= col_d;
            empty_q <= empty_d;
            merge_q <= merge_d;
            over_q  <= over_d;
            max_q   <= max_d;
        end
    end

    assign result    = win_q;
    assign win_row   = row_q;
    assign win_col   = col_q;
    assign has_empty = empty_q;
    assign can_merge = merge_q;
    assign game_over = over_q;
    assign max_tile  = max_q;

endmodule

// File: tb/tb_check_win.sv
// tb/tb_check_win.sv - randomized self-checking bench for check_win against a behavioural model
module tb_check_win;

    localparam int MAX_WIN = 11;

    typedef logic [3:0][3:0][11:0] brd_t;
    typedef struct {
        int result;
        int has_empty;
        int can_merge;
        int game_over;
        int max_tile;
        int win_row;
        int win_col;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    brd_t        board_in;
    logic        result, has_empty, can_merge, game_over;
    logic [11:0] max_tile;
    logic [1:0]  win_row, win_col;
    logic        result_b, has_empty_b, can_merge_b, game_over_b;
    logic [11:0] max_tile_b;
    logic [1:0]  win_row_b, win_col_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    check_win #(.MAX_WIN(MAX_WIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .board_in  (board_in),
        .result    (result),
        .has_empty (has_empty),
        .can_merge (can_merge),
        .game_over (game_over),
        .max_tile  (max_tile),
        .win_row   (win_row),
        .win_col   (win_col)
    );

    check_win #(.MAX_WIN(12)) dut_nowin (
        .clk       (clk),
        .rst       (rst),
        .board_in  (board_in),
        .result    (result_b),
        .has_empty (has_empty_b),
        .can_merge (can_merge_b),
        .game_over (game_over_b),
        .max_tile  (max_tile_b),
        .win_row   (win_row_b),
        .win_col   (win_col_b)
    );

    function automatic exp_t model(input brd_t b, input bit in_reset, input int max_win);
        exp_t e;
        int   vals[$];
        int   v;
        int   thr;
        e = '{default: 0};
        if (in_reset) return e;
        thr = (max_win >= 12) ? 32'h7fff_ffff : (1 << max_win);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = int'(b[r][c]);
                vals.push_back(v);
                if (v == 0) e.has_empty = 1;
                if (v >= thr && e.result == 0) begin
                    e.result  = 1;
                    e.win_row = r;
                    e.win_col = c;
                end
                if (c < 3 && v != 0 && v == int'(b[r][c+1])) e.can_merge = 1;
                if (r < 3 && v != 0 && v == int'(b[r+1][c])) e.can_merge = 1;
            end
        end
        vals.sort();
        e.max_tile  = vals[$];
        e.game_over = (e.has_empty == 0 && e.can_merge == 0 && e.result == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r);
        exp_t e;
        exp_t e2;
        rst = r;
        @(posedge clk);
        e  = model(board_in, r, MAX_WIN);
        e2 = model(board_in, r, 12);
        #1;
        chk("result",    int'(result),    e.result);
        chk("has_empty", int'(has_empty), e.has_empty);
        chk("can_merge", int'(can_merge), e.can_merge);
        chk("game_over", int'(game_over), e.game_over);
        chk("max_tile",  int'(max_tile),  e.max_tile);
        chk("win_row",   int'(win_row),   e.win_row);
        chk("win_col",   int'(win_col),   e.win_col);
        chk("nowin_result",    int'(result_b),    e2.result);
        chk("nowin_game_over", int'(game_over_b), e2.game_over);
        chk("nowin_max_tile",  int'(max_tile_b),  e2.max_tile);
    endtask

    task automatic load_checker();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                board_in[r][c] = ((r + c) % 2 == 0) ? 12'd2 : 12'd4;
    endtask

    initial begin
        int mode;
        logic [11:0] a;
        logic [11:0] b;

        rst      = 1'b1;
        board_in = '0;
        step(1'b1);
        chk("lit_reset_result",    int'(result),    0);
        chk("lit_reset_has_empty", int'(has_empty), 0);
        chk("lit_reset_game_over", int'(game_over), 0);

        step(1'b0);
        chk("lit_zero_has_empty", int'(has_empty), 1);
        chk("lit_zero_can_merge", int'(can_merge), 0);
        chk("lit_zero_max",       int'(max_tile),  0);

        board_in[1][1] = 12'h800;
        step(1'b0);
        chk("lit_800_result", int'(result),   1);
        chk("lit_800_row",    int'(win_row),  1);
        chk("lit_800_col",    int'(win_col),  1);
        chk("lit_800_max",    int'(max_tile), 12'h800);

        board_in[1][1] = 12'h000;
        board_in[2][1] = 12'h040;
        step(1'b0);
        chk("lit_040_result", int'(result),    0);
        chk("lit_040_max",    int'(max_tile),  12'h040);
        chk("lit_040_empty",  int'(has_empty), 1);

        load_checker();
        step(1'b0);
        chk("lit_checker_over",  int'(game_over), 1);
        chk("lit_checker_merge", int'(can_merge), 0);
        chk("lit_checker_win",   int'(result),    0);

        board_in[0][1] = 12'd2;
        step(1'b0);
        chk("lit_pair_merge", int'(can_merge), 1);
        chk("lit_pair_over",  int'(game_over), 0);

        load_checker();
        board_in[2][2] = 12'h7FF;
        step(1'b0);
        chk("lit_7ff_result", int'(result),    0);
        chk("lit_7ff_max",    int'(max_tile),  12'h7FF);
        chk("lit_7ff_over",   int'(game_over), 1);

        board_in[2][2] = 12'h800;
        step(1'b0);
        chk("lit_win_row",     int'(win_row),   2);
        chk("lit_win_col",     int'(win_col),   2);
        chk("lit_win_no_over", int'(game_over), 0);

        board_in       = '0;
        board_in[3][3] = 12'hFFF;
        step(1'b1);
        chk("lit_rst_result", int'(result),   0);
        chk("lit_rst_max",    int'(max_tile), 0);
        step(1'b0);
        chk("lit_rel_result",  int'(result),   1);
        chk("lit_rel_row",     int'(win_row),  3);
        chk("lit_rel_col",     int'(win_col),  3);
        chk("lit_rel_nowin",   int'(result_b), 0);

        for (int it = 0; it < 600; it++) begin
            mode = int'($urandom_range(0, 3));
            a = 12'($urandom_range(1, 4095));
            b = 12'($urandom_range(1, 4095));
            if (b == a) b = a ^ 12'h001;
            if (b == 12'h000) b = 12'h002;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    case (mode)
                        0: board_in[r][c] = ($urandom_range(0, 2) == 0) ? 12'h000
                                            : 12'(1 << $urandom_range(1, 11));
                        1: board_in[r][c] = 12'(1 << $urandom_range(1, 11));
                        2: board_in[r][c] = 12'($urandom_range(0, 4095));
                        default: board_in[r][c] = ((r + c) % 2 == 0) ? a : b;
                    endcase
                end
            end
            step($urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
